// File: rtl/speed_switch_sequencer.sv
// speed_switch_sequencer
//   Sequences the CGB double-speed switch for the clock mux. Owns KEY1
//   (0xFF4D): bit0 arms a switch and a later STOP executes it. The sequence
//   halts the CPU, drains the memory bus, waits a fixed settle time, toggles
//   the speed select and then resumes.
//
// Ports
//   I_CLK          system clock, all logic on posedge
//   I_RESET_L      asynchronous active-low reset
//   I_KEY1_WR      one-cycle strobe, CPU write to KEY1
//   I_KEY1_WDATA   KEY1 write data, only bit0 is used
//   I_STOP_REQ     one-cycle strobe, CPU executed STOP
//   I_MEM_BUSY     memory controller has a transaction in flight
//   O_KEY1_RDATA   {double_speed, 6'b111111, armed}
//   O_CPU_HALT     freezes the CPU clock enable
//   O_MEM_HOLD     memory controller must not start new transactions
//   O_DOUBLE_SPEED select line to the clock mux
//   O_SWITCH_DONE  one-cycle pulse, switch completed
//   O_ABORT        one-cycle pulse, drain timed out and no switch happened
//   O_STATE        current state encoding, for debug
//
// Handshake: I_KEY1_WR and I_STOP_REQ are single-cycle strobes with no
// back-pressure. They are acted on only in IDLE and dropped in every other
// state. O_SWITCH_DONE / O_ABORT are single-cycle pulses in RESUME with no
// ready from the receiver.
module speed_switch_sequencer #(
  parameter int P_QUIESCE_CYCLES = 255,
  parameter int P_DRAIN_TIMEOUT  = 1023,
  parameter int P_CNT_WIDTH      = 16
) (
  input  logic       I_CLK,
  input  logic       I_RESET_L,
  input  logic       I_KEY1_WR,
  input  logic [7:0] I_KEY1_WDATA,
  input  logic       I_STOP_REQ,
  input  logic       I_MEM_BUSY,
  output logic [7:0] O_KEY1_RDATA,
  output logic       O_CPU_HALT,
  output logic       O_MEM_HOLD,
  output logic       O_DOUBLE_SPEED,
  output logic       O_SWITCH_DONE,
  output logic       O_ABORT,
  output logic [2:0] O_STATE
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SETTLE = 3'd2,
    SWITCH = 3'd3,
    RESUME = 3'd4
  } state_t;

  localparam logic [P_CNT_WIDTH-1:0] DRAIN_LOAD  = P_CNT_WIDTH'(P_DRAIN_TIMEOUT - 1);
  localparam logic [P_CNT_WIDTH-1:0] SETTLE_LOAD = P_CNT_WIDTH'(P_QUIESCE_CYCLES - 1);

  state_t                 state, state_n;
  logic [P_CNT_WIDTH-1:0] count, count_n;
  logic                   armed, armed_n;
  logic                   double_q, double_n;
  // Remembers how RESUME was entered: 1 from SWITCH, 0 from a drain abort.
  logic                   resume_done, resume_done_n;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      state       <= IDLE;
      count       <= '0;
      armed       <= 1'b0;
      double_q    <= 1'b0;
      resume_done <= 1'b0;
    end else begin
      state       <= state_n;
      count       <= count_n;
      armed       <= armed_n;
      double_q    <= double_n;
      resume_done <= resume_done_n;
    end
  end

  always_comb begin
    state_n       = state;
    count_n       = count;
    armed_n       = armed;
    double_n      = double_q;
    resume_done_n = resume_done;
    case (state)
      IDLE: begin
        if (I_KEY1_WR) armed_n = I_KEY1_WDATA[0];
        // STOP looks at the armed value from before any same-cycle write.
        if (I_STOP_REQ && armed) begin
          state_n = DRAIN;
          count_n = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        if (!I_MEM_BUSY) begin
          state_n = SETTLE;
          count_n = SETTLE_LOAD;
        end else if (count == '0) begin
          state_n       = RESUME;
          resume_done_n = 1'b0;
        end else begin
          count_n = count - 1'b1;
        end
      end
      SETTLE: begin
        if (count == '0) state_n = SWITCH;
        else             count_n = count - 1'b1;
      end
      SWITCH: begin
        double_n      = ~double_q;
        armed_n       = 1'b0;
        resume_done_n = 1'b1;
        state_n       = RESUME;
      end
      RESUME: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign O_CPU_HALT     = (state == DRAIN) || (state == SETTLE) || (state == SWITCH);
  assign O_MEM_HOLD     = O_CPU_HALT;
  assign O_DOUBLE_SPEED = double_q;
  assign O_SWITCH_DONE  = (state == RESUME) && resume_done;
  assign O_ABORT        = (state == RESUME) && !resume_done;
  assign O_STATE        = state;
  assign O_KEY1_RDATA   = {double_q, 6'b111111, armed};

endmodule

// File: tb/tb_speed_switch_sequencer.sv
module tb_speed_switch_sequencer;

  localparam int Q = 4;
  localparam int T = 8;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key1_wr = 1'b0;
  logic [7:0] key1_wdata = 8'h00;
  logic       stop_req = 1'b0;
  logic       mem_busy = 1'b0;
  logic [7:0] key1_rdata;
  logic       cpu_halt, mem_hold, double_speed, switch_done, abort_p;
  logic [2:0] state;

  always #5 clk = ~clk;

  speed_switch_sequencer #(
    .P_QUIESCE_CYCLES(Q),
    .P_DRAIN_TIMEOUT (T),
    .P_CNT_WIDTH     (16)
  ) dut (
    .I_CLK         (clk),
    .I_RESET_L     (rst_n),
    .I_KEY1_WR     (key1_wr),
    .I_KEY1_WDATA  (key1_wdata),
    .I_STOP_REQ    (stop_req),
    .I_MEM_BUSY    (mem_busy),
    .O_KEY1_RDATA  (key1_rdata),
    .O_CPU_HALT    (cpu_halt),
    .O_MEM_HOLD    (mem_hold),
    .O_DOUBLE_SPEED(double_speed),
    .O_SWITCH_DONE (switch_done),
    .O_ABORT       (abort_p),
    .O_STATE       (state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // {is_done, halt_len[7:0], key1_rdata_after[7:0]}
  logic [16:0] exp_q[$];

  // reference model: architectural KEY1 state only
  logic model_armed = 1'b0;
  logic model_double = 1'b0;

  function automatic logic [7:0] model_rdata(input logic d, input logic a);
    return {d, 6'b111111, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: counts halt length and pops an expectation on every pulse
  int run_len = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (cpu_halt) begin
      run_len++;
      check("hold_follows_halt", {31'd0, mem_hold}, 32'd1);
    end else begin
      if (switch_done || abort_p) begin
        logic [16:0] e;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: done=%0b abort=%0b with nothing expected", switch_done, abort_p);
        end else begin
          e = exp_q.pop_front();
          check("pulse_done",  {31'd0, switch_done}, {31'd0, e[16]});
          check("pulse_abort", {31'd0, abort_p},     {31'd0, ~e[16]});
          check("halt_len",    run_len,              {24'd0, e[15:8]});
          check("rdata_at_pulse", {24'd0, key1_rdata}, {24'd0, e[7:0]});
          check("double_at_pulse", {31'd0, double_speed}, {31'd0, e[7]});
        end
      end
      run_len = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key1(input logic [7:0] d);
    key1_wr = 1'b1;
    key1_wdata = d;
    tick();
    key1_wr = 1'b0;
    model_armed = d[0];
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (state !== 3'd0 && n < 60) begin
      tick();
      n++;
    end
    if (state !== 3'd0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: state=%0d after %0d cycles", state, n);
    end
  endtask

  // STOP, then MEM_BUSY is high for `busy` sampled DRAIN edges.
  task automatic run_seq(input int busy, input bit junk);
    bit was_armed;
    was_armed = model_armed;
    if (model_armed) begin
      if (busy >= T)
        exp_q.push_back({1'b0, 8'(T), model_rdata(model_double, 1'b1)});
      else
        exp_q.push_back({1'b1, 8'(busy + 1 + Q + 1), model_rdata(~model_double, 1'b0)});
    end
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    mem_busy = (busy > 0);
    if (was_armed && junk) begin
      // sequence is running: these must be ignored
      key1_wr = 1'b1;
      key1_wdata = 8'($urandom_range(0, 255));
      stop_req = 1'b1;
    end
    if (busy > 0) begin
      tick();
      key1_wr = 1'b0;
      stop_req = 1'b0;
      repeat (busy - 1) tick();
      mem_busy = 1'b0;
    end else begin
      tick();
      key1_wr = 1'b0;
      stop_req = 1'b0;
    end
    if (was_armed && busy < T) begin
      model_double = ~model_double;
      model_armed = 1'b0;
    end
    wait_idle();
    tick();
    check("rdata_after_seq", {24'd0, key1_rdata}, {24'd0, model_rdata(model_double, model_armed)});
    check("idle_no_halt", {31'd0, cpu_halt}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", {24'd0, key1_rdata}, 32'h7E);
    check("rst_halt", {31'd0, cpu_halt}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_state", {29'd0, state}, 32'd0);
    check("post_rst_outs", {27'd0, cpu_halt, mem_hold, double_speed, switch_done, abort_p}, 32'd0);
    check("post_rst_rdata", {24'd0, key1_rdata}, 32'h7E);

    // 2. two clean switches on an idle bus
    write_key1(8'h01);
    check("armed_rdata", {24'd0, key1_rdata}, 32'h7F);
    run_seq(0, 1'b0);
    check("double_on", {31'd0, double_speed}, 32'd1);
    check("rdata_fe", {24'd0, key1_rdata}, 32'hFE);
    write_key1(8'h01);
    run_seq(0, 1'b0);
    check("double_off", {31'd0, double_speed}, 32'd0);

    // 3. STOP while not armed
    run_seq(0, 1'b0);
    check("unarmed_state", {29'd0, state}, 32'd0);

    // 4. busy bus for 3 drain cycles
    write_key1(8'h01);
    run_seq(3, 1'b1);

    // 5. bus stuck busy -> abort
    write_key1(8'h01);
    run_seq(T + 3, 1'b0);
    check("abort_armed_kept", {31'd0, key1_rdata[0]}, 32'd1);

    // 6a. reset during SETTLE
    write_key1(8'h01);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    repeat (3) tick();
    check("in_settle", {29'd0, state}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_halt", {30'd0, cpu_halt, mem_hold}, 32'd0);
    check("mid_rst_double", {31'd0, double_speed}, 32'd0);
    check("mid_rst_rdata", {24'd0, key1_rdata}, 32'h7E);
    model_armed = 1'b0;
    model_double = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // 6b. write and STOP together with armed=0
    key1_wr = 1'b1;
    key1_wdata = 8'h01;
    stop_req = 1'b1;
    tick();
    key1_wr = 1'b0;
    stop_req = 1'b0;
    model_armed = 1'b1;
    check("wrstop_state", {29'd0, state}, 32'd0);
    check("wrstop_halt", {31'd0, cpu_halt}, 32'd0);
    check("wrstop_rdata", {24'd0, key1_rdata}, 32'h7F);

    // randomized sequences
    for (int i = 0; i < 16; i++) begin
      int b;
      if ($urandom_range(0, 3) != 0) write_key1(8'($urandom_range(0, 255)));
      b = ($urandom_range(0, 4) == 0) ? int'($urandom_range(T, T + 2)) : int'($urandom_range(0, 5));
      run_seq(b, 1'($urandom_range(0, 1)));
    end

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
